// File: rtl/axis_dir_filter.sv
// Multi-axis direction classifier: per-axis thresholds with hysteresis and an
// N-sample persistence filter, emitting registered 4-bit direction codes.
module axis_dir_filter #(
  parameter int unsigned W      = 12,
  parameter int unsigned N_AXES = 2,
  parameter int signed   POS_TH = 256,
  parameter int signed   NEG_TH = -256,
  parameter int unsigned HYST   = 32,
  parameter int unsigned HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [N_AXES*W-1:0]   axes,
  output logic [4*N_AXES-1:0]   dir,
  output logic                  dir_valid,
  output logic                  changed
);

  localparam int unsigned EW = W + 1;
  localparam int unsigned CW = $clog2(HOLD + 1);

  // Thresholds widened by one bit so the hysteresis-adjusted values cannot wrap
  localparam logic signed [EW-1:0] POS_ENTER = EW'(POS_TH);
  localparam logic signed [EW-1:0] POS_KEEP  = EW'(POS_TH - int'(HYST));
  localparam logic signed [EW-1:0] NEG_ENTER = EW'(NEG_TH);
  localparam logic signed [EW-1:0] NEG_KEEP  = EW'(NEG_TH + int'(HYST));

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_NEG  = 2'b01;
  localparam logic [1:0] ST_POS  = 2'b10;

  if ((POS_TH - int'(HYST)) <= (NEG_TH + int'(HYST))) begin : g_bad_hyst
    $error("axis_dir_filter: POS_TH-HYST must exceed NEG_TH+HYST");
  end
  if (W < 4 || W > 16) begin : g_bad_w
    $error("axis_dir_filter: W out of range 4..16");
  end
  if (N_AXES < 1 || N_AXES > 8) begin : g_bad_n
    $error("axis_dir_filter: N_AXES out of range 1..8");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("axis_dir_filter: HOLD out of range 1..255");
  end

  function automatic logic [3:0] enc(input logic [1:0] st);
    case (st)
      ST_POS:  enc = 4'b1000;
      ST_NEG:  enc = 4'b0010;
      default: enc = 4'b0000;
    endcase
  endfunction

  logic [4*N_AXES-1:0] dir_d;
  logic [N_AXES-1:0]   diff_c;

  for (genvar g = 0; g < N_AXES; g++) begin : g_axis
    logic signed [W-1:0]  s;
    logic signed [EW-1:0] se;
    logic [1:0]           st_q, st_d, cand_q, cand_d, tgt;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_upd;

    assign s  = axes[g*W +: W];
    assign se = {s[W-1], s};

    // Target classification; the keep thresholds apply only to the current state
    always_comb begin
      tgt = ST_IDLE;
      if (se >= POS_ENTER || (st_q == ST_POS && se >= POS_KEEP)) begin
        tgt = ST_POS;
      end else if (se <= NEG_ENTER || (st_q == ST_NEG && se <= NEG_KEEP)) begin
        tgt = ST_NEG;
      end
    end

    always_comb begin
      st_d    = st_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      cnt_upd = '0;
      if (sample_valid) begin
        if (tgt == st_q) begin
          cnt_d = '0;
        end else begin
          if (cnt_q == '0 || tgt != cand_q) begin
            cand_d  = tgt;
            cnt_upd = CW'(1);
          end else begin
            cnt_upd = cnt_q + CW'(1);
          end
          cnt_d = cnt_upd;
          if (cnt_upd == CW'(HOLD)) begin
            st_d  = tgt;
            cnt_d = '0;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q   <= ST_IDLE;
        cand_q <= ST_IDLE;
        cnt_q  <= '0;
      end else begin
        st_q   <= st_d;
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
      end
    end

    assign dir_d[g*4 +: 4] = enc(st_d);
    assign diff_c[g]       = (st_d != st_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir       <= '0;
      dir_valid <= 1'b0;
      changed   <= 1'b0;
    end else begin
      dir_valid <= sample_valid;
      changed   <= sample_valid & (|diff_c);
      if (sample_valid) begin
        dir <= dir_d;
      end
    end
  end

endmodule

// File: tb/tb_axis_dir_filter.sv
// Scoreboarded bench for axis_dir_filter: a behavioural model queues expected
// codes per accepted sample set; a negedge monitor pops and compares them.
module tb_axis_dir_filter;

  localparam int W      = 12;
  localparam int NA     = 2;
  localparam int POS_TH = 256;
  localparam int NEG_TH = -256;
  localparam int HYST   = 32;
  localparam int HOLD   = 4;
  localparam int C_POS  = 8;
  localparam int C_NEG  = 2;
  localparam int C_IDLE = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [NA*W-1:0] axes = '0;
  logic [4*NA-1:0] dir;
  logic          dir_valid;
  logic          changed;

  axis_dir_filter #(
    .W(W), .N_AXES(NA), .POS_TH(POS_TH), .NEG_TH(NEG_TH), .HYST(HYST), .HOLD(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .axes(axes),
    .dir(dir), .dir_valid(dir_valid), .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_st[NA];
  int   m_cand[NA];
  int   m_cnt[NA];
  logic [7:0] last_dir = '0;
  logic       rst_prev = 1'b1;

  function automatic int target(input int s, input int st);
    if (s >= POS_TH || (st == C_POS && s >= POS_TH - HYST)) return C_POS;
    if (s <= NEG_TH || (st == C_NEG && s <= NEG_TH + HYST)) return C_NEG;
    return C_IDLE;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NA; k++) begin
      m_st[k] = C_IDLE; m_cand[k] = C_IDLE; m_cnt[k] = 0;
    end
    sb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one valid sample set and queue the model's expected response
  task automatic send(input int a0, input int a1);
    exp_t e;
    int   vals[NA];
    int   t;
    vals[0] = a0; vals[1] = a1;
    e = '0;
    for (int k = 0; k < NA; k++) begin
      t = target(vals[k], m_st[k]);
      if (t == m_st[k]) begin
        m_cnt[k] = 0;
      end else begin
        if (m_cnt[k] == 0 || t != m_cand[k]) begin
          m_cand[k] = t; m_cnt[k] = 1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        if (m_cnt[k] == HOLD) begin
          m_st[k] = t; m_cnt[k] = 0; e.c = 1'b1;
        end
      end
      e.d[k*4 +: 4] = 4'(m_st[k]);
    end
    sb.push_back(e);
    sample_valid = 1'b1;
    axes = {12'(a1), 12'(a0)};
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (dir_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: dir_valid=1 dir=%h with no sample pending", dir);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dir !== e.d || changed !== e.c) begin
          errors++;
          $display("FAIL sb_update: dir=%h changed=%b, expected dir=%h changed=%b",
                   dir, changed, e.d, e.c);
        end
      end
    end else if (!reset && !rst_prev) begin
      checks++;
      if (changed !== 1'b0 || dir !== last_dir) begin
        errors++;
        $display("FAIL sb_hold: dir=%h changed=%b without dir_valid, expected dir=%h changed=0",
                 dir, changed, last_dir);
      end
    end
    last_dir = dir;
    rst_prev = reset;
  end

  task automatic test_reset();
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dir !== 8'h00 || dir_valid !== 1'b0 || changed !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: dir=%h dir_valid=%b changed=%b, expected 00/0/0",
                 dir, dir_valid, changed);
      end
      idle(1);
    end
  endtask

  task automatic test_persistence();
    do_reset(1);
    repeat (3) send(300, 0);
    send(100, 0);
    checks++;
    if (dir !== 8'h00) begin
      errors++; $display("FAIL persist_short: dir=%h, expected 00", dir);
    end
    for (int i = 0; i < 4; i++) begin
      send(300, 0);
      checks++;
      if (i < 3 && dir !== 8'h00) begin
        errors++; $display("FAIL persist_early: dir=%h after %0d samples, expected 00", dir, i + 1);
      end else if (i == 3 && (dir !== 8'h08 || changed !== 1'b1 || dir_valid !== 1'b1)) begin
        errors++;
        $display("FAIL persist_enter: dir=%h changed=%b, expected 08 changed=1", dir, changed);
      end
    end
    send(300, 0);
    checks++;
    if (dir_valid !== 1'b1 || changed !== 1'b0 || dir !== 8'h08) begin
      errors++;
      $display("FAIL persist_steady: dir_valid=%b changed=%b dir=%h, expected 1/0/08",
               dir_valid, changed, dir);
    end
  endtask

  task automatic test_hysteresis();
    repeat (10) send(224, 0);
    checks++;
    if (dir !== 8'h08) begin
      errors++; $display("FAIL hyst_keep: dir=%h, expected 08", dir);
    end
    for (int i = 0; i < 4; i++) begin
      send(223, 0);
      checks++;
      if (dir !== ((i == 3) ? 8'h00 : 8'h08)) begin
        errors++;
        $display("FAIL hyst_release: dir=%h after %0d samples, expected %h",
                 dir, i + 1, (i == 3) ? 8'h00 : 8'h08);
      end
    end
    repeat (4) send(0, -256);
    checks++;
    if (dir !== 8'h20) begin
      errors++; $display("FAIL neg_enter: dir=%h, expected 20", dir);
    end
    for (int i = 0; i < 6; i++) begin
      send(0, 255);
      checks++;
      if (dir[7:4] === 4'h8) begin
        errors++; $display("FAIL no_pos_255: dir=%h, axis1 must not be 8", dir);
      end
    end
    checks++;
    if (dir !== 8'h00) begin
      errors++; $display("FAIL neg_release: dir=%h, expected 00", dir);
    end
  endtask

  task automatic test_reversal();
    do_reset(1);
    repeat (4) send(300, 0);
    for (int i = 0; i < 4; i++) begin
      send(-2048, 0);
      checks++;
      if (dir[3:0] !== ((i == 3) ? 4'h2 : 4'h8)) begin
        errors++;
        $display("FAIL reversal: dir=%h after %0d samples, expected axis0 %h",
                 dir, i + 1, (i == 3) ? 4'h2 : 4'h8);
      end
    end
    repeat (4) send(-2048, 2047);
    checks++;
    if (dir !== 8'h82) begin
      errors++; $display("FAIL extreme_pos: dir=%h, expected 82", dir);
    end
  endtask

  task automatic test_gapped();
    int seq[5];
    seq = '{300, 300, -300, 300, 300};
    do_reset(1);
    foreach (seq[i]) begin
      send(seq[i], 0);
      checks++;
      if (dir !== 8'h00 || changed !== 1'b0) begin
        errors++;
        $display("FAIL interrupted: dir=%h changed=%b at step %0d, expected 00/0", dir, changed, i);
      end
    end
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(300, 0);
      if (i < 3) idle(1 + 2 * i);
    end
    checks++;
    if (dir !== 8'h08 || changed !== 1'b1) begin
      errors++; $display("FAIL gapped: dir=%h changed=%b, expected 08/1", dir, changed);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    repeat (3) send(300, 0);
    reset = 1'b1;
    sample_valid = 1'b1;
    axes = {12'(0), 12'(300)};
    @(posedge clk); #1;
    reset = 1'b0;
    sample_valid = 1'b0;
    model_reset();
    checks++;
    if (dir !== 8'h00 || dir_valid !== 1'b0 || changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: dir=%h dir_valid=%b changed=%b, expected 00/0/0",
               dir, dir_valid, changed);
    end
    send(300, 0);
    checks++;
    if (dir !== 8'h00) begin
      errors++; $display("FAIL reset_mid_after: dir=%h, expected 00", dir);
    end
  endtask

  function automatic int pick();
    case ($urandom_range(0, 7))
      0: return 300;
      1: return -300;
      2: return 224;
      3: return 223;
      4: return -224;
      5: return -223;
      6: return int'($urandom_range(0, 4095)) - 2048;
      default: return 0;
    endcase
  endfunction

  task automatic test_back_to_back();
    int a0, a1;
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      a0 = (i % 16 < 8) ? 300 : pick();
      a1 = pick();
      send(a0, a1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d updates still pending, expected 0", sb.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_persistence();
    test_hysteresis();
    test_reversal();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
